// File: rtl/sprite_palette_bank_if.sv
// sprite_palette_bank_if
//   Bundles the palette-write port, the pixel lookup port and the status
//   outputs of sprite_palette_bank.
//   master : sprite loader / pixel pipeline side (drives requests)
//   slave  : palette bank side (returns lookup results and busy)
//   Signals:
//     wr_en, wr_pal, wr_index, wr_color   palette entry write
//     rd_valid_in, rd_pal, rd_index       lookup request
//     rd_valid_out, red, green, blue,     lookup result
//     transparent
//     busy                                clear sequence in progress
interface sprite_palette_bank_if #(
  parameter int PAL_W   = 2,
  parameter int INDEX_W = 4
);
  logic               wr_en;
  logic [PAL_W-1:0]   wr_pal;
  logic [INDEX_W-1:0] wr_index;
  logic [11:0]        wr_color;
  logic               rd_valid_in;
  logic [PAL_W-1:0]   rd_pal;
  logic [INDEX_W-1:0] rd_index;
  logic               rd_valid_out;
  logic [3:0]         red;
  logic [3:0]         green;
  logic [3:0]         blue;
  logic               transparent;
  logic               busy;

  modport master (
    output wr_en, wr_pal, wr_index, wr_color,
    output rd_valid_in, rd_pal, rd_index,
    input  rd_valid_out, red, green, blue, transparent, busy
  );

  modport slave (
    input  wr_en, wr_pal, wr_index, wr_color,
    input  rd_valid_in, rd_pal, rd_index,
    output rd_valid_out, red, green, blue, transparent, busy
  );
endinterface

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
//   Runtime-loadable multi-palette colour lookup for sprite rendering.
//   NUM_PALETTES palettes of 2^INDEX_W entries of 12-bit {R,G,B}.
//   After reset every entry is overwritten with CLEAR_COLOR before the
//   block accepts writes or lookups. Lookups have a fixed 2-register
//   latency with full throughput and a transparency flag.
//   Ports:
//     Clk    system clock
//     Reset  synchronous, active-high reset
//     bus    sprite_palette_bank_if.slave (write port, lookup port, busy)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | writing CLEAR_COLOR to one entry per cycle; traffic ignored
//   RUN   | normal operation; writes and lookups accepted until Reset
module sprite_palette_bank #(
  parameter int          INDEX_W           = 4,
  parameter int          NUM_PALETTES      = 4,
  parameter int          PAL_W             = 2,
  parameter logic [11:0] CLEAR_COLOR       = 12'h000,
  parameter int          TRANSPARENT_INDEX = 0,
  parameter bit          TRANSPARENT_EN    = 1'b1
) (
  input logic                  Clk,
  input logic                  Reset,
  sprite_palette_bank_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TOTAL   = NUM_PALETTES * ENTRIES;
  localparam int ADDR_W  = PAL_W + INDEX_W;

  // One bit wider than PAL_W so NUM_PALETTES == 2^PAL_W is representable.
  localparam logic [PAL_W:0]   NUM_PAL_L = (PAL_W+1)'(NUM_PALETTES);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(TOTAL - 1);
  localparam logic [INDEX_W-1:0] T_IDX   = INDEX_W'(TRANSPARENT_INDEX);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                clr_we;
  logic                clr_last;

  logic [11:0]         mem [TOTAL];

  logic                wr_pal_ok, rd_pal_ok;
  logic                usr_we;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic                rd_hit;
  logic [11:0]         rd_color_d;
  logic                rd_transp_d;

  logic                s1_valid_q;
  logic [11:0]         s1_color_q;
  logic                s1_transp_q;
  logic                out_valid_q;
  logic [11:0]         out_color_q;
  logic                out_transp_q;

  // The flat counter {palette, index} only ever reaches TOTAL-1, so with a
  // non-power-of-two palette count the unused palette codes are never touched.
  assign clr_last = (clr_cnt_q == LAST_CNT);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_last) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset)                                 clr_cnt_q <= '0;
    else if (state_q == CLEAR && !clr_last)    clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  assign wr_pal_ok = ({1'b0, bus.wr_pal} < NUM_PAL_L);
  assign rd_pal_ok = ({1'b0, bus.rd_pal} < NUM_PAL_L);
  assign wr_addr   = {bus.wr_pal, bus.wr_index};
  assign rd_addr   = {bus.rd_pal, bus.rd_index};
  assign usr_we    = (state_q == RUN) && bus.wr_en && wr_pal_ok;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (clr_we)      mem[clr_cnt_q] <= CLEAR_COLOR;
      else if (usr_we) mem[wr_addr]   <= bus.wr_color;
    end
  end

  // Same-cycle write to the entry being looked up is forwarded (write-first).
  assign rd_hit = usr_we && (wr_addr == rd_addr);

  always_comb begin
    rd_color_d = 12'h000;
    if (rd_pal_ok) begin
      if (rd_hit) rd_color_d = bus.wr_color;
      else        rd_color_d = mem[rd_addr];
    end
  end

  assign rd_transp_d = !rd_pal_ok || (TRANSPARENT_EN && (bus.rd_index == T_IDX));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_color_q  <= 12'h000;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= (state_q == RUN) && bus.rd_valid_in;
      if ((state_q == RUN) && bus.rd_valid_in) begin
        s1_color_q  <= rd_color_d;
        s1_transp_q <= rd_transp_d;
      end
    end
  end

  // Outputs hold their last result while no lookup completes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_color_q  <= 12'h000;
      out_transp_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_color_q  <= s1_color_q;
        out_transp_q <= s1_transp_q;
      end
    end
  end

  assign bus.rd_valid_out = out_valid_q;
  assign bus.red          = out_color_q[11:8];
  assign bus.green        = out_color_q[7:4];
  assign bus.blue         = out_color_q[3:0];
  assign bus.transparent  = out_transp_q;
  assign bus.busy         = (state_q == CLEAR);

endmodule

// File: tb/tb_sprite_palette_bank.sv
module tb_sprite_palette_bank;
  logic Clk;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic seen;

  sprite_palette_bank_if #(.PAL_W(2), .INDEX_W(4)) b0 ();
  sprite_palette_bank_if #(.PAL_W(2), .INDEX_W(4)) b1 ();

  sprite_palette_bank u0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  sprite_palette_bank #(.NUM_PALETTES(3)) u1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] col(input int i);
    logic [3:0] a;
    a = i[3:0];
    return {a, ~a, a + 4'd3};
  endfunction

  task automatic idle();
    b0.wr_en = 1'b0; b0.rd_valid_in = 1'b0;
    b1.wr_en = 1'b0; b1.rd_valid_in = 1'b0;
  endtask

  task automatic wr0(input logic [1:0] p, input logic [3:0] i, input logic [11:0] c);
    b0.wr_en = 1'b1; b0.wr_pal = p; b0.wr_index = i; b0.wr_color = c;
  endtask

  task automatic rd0(input logic [1:0] p, input logic [3:0] i);
    b0.rd_valid_in = 1'b1; b0.rd_pal = p; b0.rd_index = i;
  endtask

  // Full lookup on u0: request cycle, one pipeline cycle, then result.
  task automatic look0(input string tag, input logic [1:0] p, input logic [3:0] i,
                       input logic [11:0] ec, input logic et);
    rd0(p, i);
    step();
    b0.rd_valid_in = 1'b0;
    chk({tag, "_lat1"}, b0.rd_valid_out, 1'b0);
    step();
    chk({tag, "_valid"}, b0.rd_valid_out, 1'b1);
    chk({tag, "_color"}, {b0.red, b0.green, b0.blue}, ec);
    chk({tag, "_transp"}, b0.transparent, et);
  endtask

  task automatic look1(input string tag, input logic [1:0] p, input logic [3:0] i,
                       input logic [11:0] ec, input logic et);
    b1.rd_valid_in = 1'b1; b1.rd_pal = p; b1.rd_index = i;
    step();
    b1.rd_valid_in = 1'b0;
    step();
    chk({tag, "_valid"}, b1.rd_valid_out, 1'b1);
    chk({tag, "_color"}, {b1.red, b1.green, b1.blue}, ec);
    chk({tag, "_transp"}, b1.transparent, et);
  endtask

  initial begin
    b0.wr_pal = '0; b0.wr_index = '0; b0.wr_color = '0; b0.rd_pal = '0; b0.rd_index = '0;
    b1.wr_pal = '0; b1.wr_index = '0; b1.wr_color = '0; b1.rd_pal = '0; b1.rd_index = '0;
    idle();
    Reset = 1'b1;
    step();
    step();
    chk("rst_busy", b0.busy, 1'b1);
    chk("rst_valid", b0.rd_valid_out, 1'b0);
    chk("rst_color", {b0.red, b0.green, b0.blue}, 12'h000);
    chk("rst_transp", b0.transparent, 1'b0);
    chk("rst_busy_u1", b1.busy, 1'b1);

    Reset = 1'b0;
    n = 0;
    while (b0.busy && n < 200) begin step(); n++; end
    chk("clear_len", 16'(n), 16'd64);
    chk("u1_clear_done", b1.busy, 1'b0);

    // First lookups straight after the clear.
    look0("rd_p3i15", 2'd3, 4'd15, 12'h000, 1'b0);
    step();
    chk("valid_drop", b0.rd_valid_out, 1'b0);
    look0("rd_p3i0", 2'd3, 4'd0, 12'h000, 1'b1);
    step();
    chk("hold_transp", b0.transparent, 1'b1);

    // Write then read on the following cycle.
    wr0(2'd1, 4'd5, 12'hE92);
    step();
    b0.wr_en = 1'b0;
    rd0(2'd1, 4'd5);
    step();
    b0.rd_valid_in = 1'b0;
    step();
    chk("wr_red", b0.red, 4'hE);
    chk("wr_green", b0.green, 4'h9);
    chk("wr_blue", b0.blue, 4'h2);

    // Same-cycle write and read: write-first.
    wr0(2'd2, 4'd7, 12'hB32);
    rd0(2'd2, 4'd7);
    step();
    idle();
    step();
    chk("wfirst_color", {b0.red, b0.green, b0.blue}, 12'hB32);

    // Write one cycle after the read does not reach the in-flight lookup.
    rd0(2'd2, 4'd8);
    step();
    b0.rd_valid_in = 1'b0;
    wr0(2'd2, 4'd8, 12'h660);
    step();
    b0.wr_en = 1'b0;
    chk("late_wr_valid", b0.rd_valid_out, 1'b1);
    chk("late_wr_color", {b0.red, b0.green, b0.blue}, 12'h000);
    look0("late_wr_after", 2'd2, 4'd8, 12'h660, 1'b0);

    // Back-to-back stream over palette 0.
    for (int i = 0; i < 16; i++) begin
      wr0(2'd0, 4'(i), col(i));
      step();
    end
    b0.wr_en = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) rd0(2'd0, 4'(k));
      else        b0.rd_valid_in = 1'b0;
      step();
      if (k >= 1) begin
        chk($sformatf("stream%0d_valid", k - 1), b0.rd_valid_out, 1'b1);
        chk($sformatf("stream%0d_color", k - 1), {b0.red, b0.green, b0.blue}, col(k - 1));
        chk($sformatf("stream%0d_transp", k - 1), b0.transparent, (k == 1));
      end
    end
    step();
    chk("stream_end", b0.rd_valid_out, 1'b0);

    // Reset with a lookup in flight.
    rd0(2'd0, 4'd3);
    step();
    Reset = 1'b1;
    step();
    chk("midrd_valid", b0.rd_valid_out, 1'b0);
    chk("midrd_busy", b0.busy, 1'b1);
    chk("midrd_color", {b0.red, b0.green, b0.blue}, 12'h000);
    chk("midrd_transp", b0.transparent, 1'b0);
    Reset = 1'b0;

    // Traffic during the clear is ignored; reset again at clear cycle 30.
    wr0(2'd0, 4'd1, 12'hABC);
    rd0(2'd0, 4'd2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= b0.rd_valid_out;
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("reclr_busy", b0.busy, 1'b1);
    n = 0;
    while (b0.busy && n < 200) begin
      step();
      n++;
      seen |= b0.rd_valid_out;
    end
    idle();
    chk("reclr_len", 16'(n), 16'd64);
    step();
    seen |= b0.rd_valid_out;
    chk("busy_no_result", seen, 1'b0);
    look0("reclr_p0i1", 2'd0, 4'd1, 12'h000, 1'b0);
    look0("reclr_p1i5", 2'd1, 4'd5, 12'h000, 1'b0);
    look0("reclr_p2i7", 2'd2, 4'd7, 12'h000, 1'b0);

    // Three-palette instance: palette 3 is out of range.
    b1.wr_en = 1'b1; b1.wr_pal = 2'd3; b1.wr_index = 4'd4; b1.wr_color = 12'h777;
    step();
    b1.wr_pal = 2'd2; b1.wr_index = 4'd9; b1.wr_color = 12'h5A5;
    step();
    b1.wr_en = 1'b0;
    look1("oor_p3i4", 2'd3, 4'd4, 12'h000, 1'b1);
    look1("oor_p0i4", 2'd0, 4'd4, 12'h000, 1'b0);
    look1("oor_p1i4", 2'd1, 4'd4, 12'h000, 1'b0);
    look1("oor_p2i4", 2'd2, 4'd4, 12'h000, 1'b0);
    look1("oor_p2i9", 2'd2, 4'd9, 12'h5A5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
